// File: rtl/codec_expand.sv
// codec_expand: expands 16-bit signed samples to 24 bits through a 2-entry FIFO,
// with a soft-mute FSM that ramps attenuation up/down one step per accepted sample.
// Optional macro CODEC_EXPAND_FILL_EN: fill the low byte from a 16-bit Galois LFSR
// instead of zeros.
module codec_expand (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        mute,
    output logic [23:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        muted
);

    typedef enum logic [1:0] {
        StRun,
        StRampDown,
        StMuted,
        StRampUp
    } state_e;

    state_e             state_q, state_d;
    logic [2:0]         att_q, att_d;

    logic [23:0]        mem_q [2];
    logic               rd_ptr_q;
    logic               wr_ptr_q;
    logic [1:0]         count_q, count_d;
    logic               in_ready_q;

    logic               push;
    logic               pop;
    logic [7:0]         fill;
    logic signed [23:0] word;
    logic signed [23:0] shifted;
    logic [23:0]        store_val;

    // in_ready is the registered "not full" flag, so a full FIFO refuses pushes even
    // on a cycle where it is also popped.
    assign push      = in_valid && in_ready_q;
    assign pop       = (count_q != 2'd0) && out_ready;
    assign in_ready  = in_ready_q;
    assign out_valid = (count_q != 2'd0);
    assign out_data  = (count_q != 2'd0) ? mem_q[rd_ptr_q] : 24'h000000;
    assign muted     = (state_q == StMuted);

`ifdef CODEC_EXPAND_FILL_EN
    logic [15:0] lfsr_q, lfsr_d;

    assign fill = lfsr_q[7:0];

    // Galois LFSR, taps 16,14,13,11; steps after its byte has been used by a push.
    always_comb begin
        lfsr_d = lfsr_q;
        if (push) begin
            lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ 16'hB400) : (lfsr_q >> 1);
        end
    end

    // LFSR register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    assign fill = 8'h00;
`endif

    // Value stored at push time: sign-preserving shift by the current attenuation,
    // or silence while fully muted.
    always_comb begin
        word      = {in_data, fill};
        shifted   = word >>> att_q;
        store_val = (state_q == StMuted) ? 24'h000000 : shifted;
    end

    // FIFO occupancy next-state.
    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 2'd1;
        end else if (!push && pop) begin
            count_d = count_q - 2'd1;
        end
    end

    // FIFO storage, pointers and registered ready.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_q[0]   <= 24'h000000;
            mem_q[1]   <= 24'h000000;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            in_ready_q <= 1'b0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= store_val;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q    <= count_d;
            in_ready_q <= (count_d != 2'd2);
        end
    end

    // Mute FSM next-state: att steps follow the current state for the accepted sample;
    // a mute level change then overrides the state, keeping att.
    always_comb begin
        state_d = state_q;
        att_d   = att_q;
        unique case (state_q)
            StRun: begin
                if (mute) begin
                    state_d = StRampDown;
                end
            end
            StRampDown: begin
                if (push) begin
                    if (att_q == 3'd7) begin
                        state_d = StMuted;
                    end else begin
                        att_d = att_q + 3'd1;
                    end
                end
                if (!mute) begin
                    state_d = StRampUp;
                end
            end
            StMuted: begin
                if (!mute) begin
                    state_d = StRampUp;
                end
            end
            StRampUp: begin
                if (push) begin
                    if (att_q == 3'd0) begin
                        state_d = StRun;
                    end else begin
                        att_d = att_q - 3'd1;
                    end
                end
                if (mute) begin
                    state_d = StRampDown;
                end
            end
            default: begin
                state_d = StRun;
                att_d   = 3'd0;
            end
        endcase
    end

    // Mute FSM state and attenuation registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StRun;
            att_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            att_q   <= att_d;
        end
    end

endmodule

// File: tb/tb_codec_expand.sv
// Self-checking bench for codec_expand: directed steps plus randomized traffic, all
// checked against a queue-based reference model of the FIFO and mute ramp.
module tb_codec_expand;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] in_data = 16'h0000;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        mute = 1'b0;
    logic [23:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        muted;

    codec_expand dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .mute     (mute),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .muted    (muted)
    );

    always #5 clk = ~clk;

`ifdef CODEC_EXPAND_FILL_EN
    localparam bit FillEn = 1'b1;
`else
    localparam bit FillEn = 1'b0;
`endif

    localparam int ModeRun   = 0;
    localparam int ModeDown  = 1;
    localparam int ModeMuted = 2;
    localparam int ModeUp    = 3;

    int          n_assert = 0;
    int          n_fail   = 0;

    // Reference model state.
    logic [23:0] mq[$];
    bit          m_ready;
    int          m_mode;
    int          m_att;
    logic [15:0] m_lfsr;

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Predict the effect of the coming clock edge given the currently driven inputs.
    task automatic model_step();
        bit                 push;
        bit                 pop;
        int                 v;
        int                 old;
        logic signed [15:0] sd;
        logic [7:0]         fill;
        if (!rst) begin
            mq.delete();
            m_ready = 1'b0;
            m_mode  = ModeRun;
            m_att   = 0;
            m_lfsr  = 16'hACE1;
            return;
        end
        push = in_valid && m_ready;
        pop  = (mq.size() != 0) && out_ready;
        if (pop) void'(mq.pop_front());
        if (push) begin
            fill = FillEn ? m_lfsr[7:0] : 8'h00;
            if (m_mode == ModeMuted) begin
                v = 0;
            end else begin
                sd = in_data;
                v  = sd;
                v  = v * 256 + int'(fill);
                v  = v >>> m_att;
            end
            mq.push_back(v[23:0]);
            if (FillEn) m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
        end
        m_ready = (mq.size() < 2);
        old = m_mode;
        if (push && old == ModeDown) begin
            if (m_att == 7) m_mode = ModeMuted;
            else m_att++;
        end
        if (push && old == ModeUp) begin
            if (m_att == 0) m_mode = ModeRun;
            else m_att--;
        end
        if (mute && (old == ModeRun || old == ModeUp)) m_mode = ModeDown;
        if (!mute && (old == ModeDown || old == ModeMuted)) m_mode = ModeUp;
    endtask

    task automatic check_model();
        chk("in_ready", in_ready, m_ready);
        chk("out_valid", out_valid, mq.size() != 0);
        chk("muted", muted, m_mode == ModeMuted);
        if (mq.size() != 0) chk("out_data", out_data, mq[0]);
    endtask

    // Drive inputs at the falling edge, step the model, check at the next falling edge.
    task automatic cycle(input bit r, input bit iv, input logic [15:0] d, input bit m,
                         input bit orr);
        rst       = r;
        in_valid  = iv;
        in_data   = d;
        mute      = m;
        out_ready = orr;
        model_step();
        @(negedge clk);
        check_model();
    endtask

    logic [23:0] ramp_tbl [9];
    logic [7:0]  fill_bytes [8];
    bit          varies;
    bit          r_rst;
    bit          r_mute;

    initial begin
        ramp_tbl = '{24'h400000, 24'h200000, 24'h100000, 24'h080000, 24'h040000,
                     24'h020000, 24'h010000, 24'h008000, 24'h000000};

        // Reset state.
        cycle(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 24'h000000);
        chk("rst_muted", muted, 1'b0);
        cycle(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
        chk("release_in_ready", in_ready, 1'b1);

        // Single sample, latency 1.
        cycle(1'b1, 1'b1, 16'h1234, 1'b0, 1'b1);
        chk("lat1_valid", out_valid, 1'b1);
`ifndef CODEC_EXPAND_FILL_EN
        chk("lat1_data", out_data, 24'h123400);
`endif
        cycle(1'b1, 1'b0, 16'h0, 1'b0, 1'b1);

        // Extremes, with simultaneous push/pop at occupancy 1.
        cycle(1'b1, 1'b1, 16'h7FFF, 1'b0, 1'b1);
`ifndef CODEC_EXPAND_FILL_EN
        chk("max_pos", out_data, 24'h7FFF00);
`endif
        cycle(1'b1, 1'b1, 16'h8000, 1'b0, 1'b1);
`ifndef CODEC_EXPAND_FILL_EN
        chk("max_neg", out_data, 24'h800000);
`endif
        cycle(1'b1, 1'b0, 16'h0, 1'b0, 1'b1);

        // Backpressure: A, B accepted, C refused until space frees.
        cycle(1'b1, 1'b1, 16'h1111, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 16'h2222, 1'b0, 1'b0);
        chk("full_ready", in_ready, 1'b0);
        cycle(1'b1, 1'b1, 16'h3333, 1'b0, 1'b0);
        chk("full_ready_hold", in_ready, 1'b0);
`ifndef CODEC_EXPAND_FILL_EN
        chk("stall_head_a", out_data, 24'h111100);
`endif
        cycle(1'b1, 1'b1, 16'h3333, 1'b0, 1'b1);
`ifndef CODEC_EXPAND_FILL_EN
        chk("order_b", out_data, 24'h222200);
`endif
        cycle(1'b1, 1'b1, 16'h3333, 1'b0, 1'b1);
`ifndef CODEC_EXPAND_FILL_EN
        chk("order_c", out_data, 24'h333300);
`endif
        cycle(1'b1, 1'b0, 16'h0, 1'b0, 1'b1);
        chk("drained", out_valid, 1'b0);

        // Soft mute ramp down, then back up to RUN.
        cycle(1'b1, 1'b0, 16'h0, 1'b1, 1'b1);
        for (int i = 0; i < 9; i++) begin
            cycle(1'b1, 1'b1, 16'h4000, 1'b1, 1'b1);
`ifndef CODEC_EXPAND_FILL_EN
            chk("ramp_down", out_data, ramp_tbl[i]);
`endif
            if (i >= 7) chk("muted_flag", muted, 1'b1);
        end
        for (int i = 0; i < 9; i++) cycle(1'b1, 1'b1, 16'h4000, 1'b0, 1'b1);
        chk("unmuted", muted, 1'b0);
        cycle(1'b1, 1'b1, 16'h4000, 1'b0, 1'b1);
`ifndef CODEC_EXPAND_FILL_EN
        chk("run_again", out_data, 24'h400000);
`endif
        cycle(1'b1, 1'b0, 16'h0, 1'b0, 1'b1);

        // Reset with two entries buffered discards them.
        cycle(1'b1, 1'b1, 16'h5555, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 16'h6666, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        chk("midrst_valid", out_valid, 1'b0);
        cycle(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 16'h0ABC, 1'b0, 1'b1);
        chk("post_rst_valid", out_valid, 1'b1);
`ifndef CODEC_EXPAND_FILL_EN
        chk("post_rst_first", out_data, 24'h0ABC00);
`endif
        cycle(1'b1, 1'b0, 16'h0, 1'b0, 1'b1);

`ifdef CODEC_EXPAND_FILL_EN
        // LFSR fill after reset.
        cycle(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 1'b1, 16'h0000, 1'b0, 1'b1);
            fill_bytes[i] = out_data[7:0];
            if (i == 0) chk("fill_first", out_data, 24'h0000E1);
        end
        varies = 1'b0;
        for (int i = 1; i < 8; i++) if (fill_bytes[i] != fill_bytes[0]) varies = 1'b1;
        chk("fill_varies", varies, 1'b1);
        cycle(1'b1, 1'b0, 16'h0, 1'b0, 1'b1);
`endif

        // Randomized traffic, occasional mute toggles and resets.
        r_mute = 1'b0;
        for (int i = 0; i < 800; i++) begin
            r_rst = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 15) == 0) r_mute = ~r_mute;
            cycle(r_rst, $urandom_range(0, 3) != 0, 16'($urandom), r_mute,
                  $urandom_range(0, 3) != 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/codec_expand.md
CODEC_EXPAND -- requirements
Module: codec_expand

Interface
REQ-001 SHALL have port clk, input, 1, rising-edge clock for all state.
REQ-002 SHALL have port rst, input, 1, synchronous active-low reset (clock clk).
REQ-003 SHALL have port in_data, input, 16, signed two's-complement 16-bit sample.
REQ-004 SHALL have port in_valid, input, 1, in_data valid.
REQ-005 SHALL have port in_ready, output, 1, block can accept a sample; transfer occurs when in_valid && in_ready.
REQ-006 SHALL have port mute, input, 1, level request for soft mute.
REQ-007 SHALL have port out_data, output, 24, signed 24-bit expanded sample.
REQ-008 SHALL have port out_valid, output, 1, out_data valid.
REQ-009 SHALL have port out_ready, input, 1, sink accepts; transfer occurs when out_valid && out_ready.
REQ-010 SHALL have port muted, output, 1, high while FSM is in MUTED.

Function
REQ-011 SHALL buffer samples in a 2-entry FIFO; in_ready is registered and equals "FIFO not full" as of the previous edge, so no push occurs while full, even if a pop happens the same cycle.
REQ-012 SHALL present the FIFO head on out_data with out_valid = FIFO not empty; a push into an empty FIFO gives out_valid=1 on the next cycle (latency 1).
REQ-013 SHALL allow a simultaneous push and pop when 1 entry is held; the occupancy stays at 1 and ordering is preserved.
REQ-014 SHALL hold out_data stable while out_valid && !out_ready.
REQ-015 SHALL compute the stored value at push time: the 24-bit word {in_data, fill[7:0]} is arithmetically shifted right by att (0..7), with sign preserved.
REQ-016 SHALL store 24'h000000 for samples pushed while the FSM is in MUTED.
REQ-017 SHALL implement FSM states RUN (att=0), RAMP_DOWN, MUTED, and RAMP_UP.
REQ-018 SHALL transition RUN->RAMP_DOWN when mute=1 and RAMP_UP->RAMP_DOWN when mute=1; these are evaluated every clock.
REQ-019 SHALL transition MUTED->RAMP_UP when mute=0 and RAMP_DOWN->RAMP_UP when mute=0, keeping the current att.
REQ-020 SHALL increment att in RAMP_DOWN on each accepted sample, using the pre-update att for that sample; the accepted sample at att=7 moves the FSM to MUTED (att held at 7).
REQ-021 SHALL decrement att in RAMP_UP on each accepted sample, using the pre-update att; the FSM enters MUTED->RAMP_UP at att=7 and, on the sample accepted at att=0, moves to RUN.
REQ-022 SHALL not change att when no sample is accepted; mute toggling with no traffic changes only the state.
REQ-023 SHALL apply a state change on the edge after mute changes; a push on that same edge uses the old state and att.

Reset
REQ-024 SHALL, on rst=0 at a clock edge, empty the FIFO and set out_valid=0, out_data=24'h000000, in_ready=0, muted=0, state=RUN, att=0, and LFSR=16'hACE1.
REQ-025 SHALL set in_ready=1 on the first edge with rst=1; a reset applied mid-operation discards all buffered samples without producing an output transfer.

Configuration
REQ-026 SHALL, when macro CODEC_EXPAND_FILL_EN is defined, use fill = low byte of a 16-bit Galois LFSR (taps 16,14,13,11; seed 16'hACE1) that advances once per accepted sample after its use.
REQ-027 SHALL, when CODEC_EXPAND_FILL_EN is not defined, use fill = 8'h00 and omit the LFSR logic; all other behaviour is identical.

Verification
REQ-028 SHALL verify (no macro) that pushing 16'h1234 with out_ready=1 gives out_data=24'h123400 with out_valid=1 one cycle later.
REQ-029 SHALL verify (no macro) that 16'h7FFF gives 24'h7FFF00 and 16'h8000 gives 24'h800000.
REQ-030 SHALL verify that with out_ready=0 and 3 samples offered (A, B, C), only A and B are accepted and in_ready=0; after out_ready=1, the outputs are A, B, C in order.
REQ-031 SHALL verify (no macro) that with mute=1 and a continuous 16'h4000 stream, the outputs are 400000, 200000, 100000, 080000, 040000, 020000, 010000, 008000, then muted=1 and 000000.
REQ-032 SHALL verify that after reset with CODEC_EXPAND_FILL_EN, the first pushed 16'h0000 gives 24'h0000E1, and that at 7 fill bytes later, fill is non-constant.
REQ-033 SHALL verify that rst=0 asserted with 2 entries buffered gives out_valid=0 on the next cycle, and that after release the first output is the first new push.
